mlp_sequencer: RTL and testbench
================================

MLP_SEQUENCER -- requirements
Module: mlp_sequencer

Interface
REQ-001 Parameter NUM_LAYERS, default 3, number of fully-connected layers run per inference.
REQ-002 Parameter TIMEOUT_CYCLES, default 2097152, maximum cycles a layer may stay busy before error.
REQ-003 Parameter WADDR_W, default 21, weight base-address width.
REQ-004 Parameter BADDR_W, default 10, bias base-address width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  one-cycle request to run one inference.
REQ-008 abort  input  1  synchronous cancel of the inference in progress.
REQ-009 busy  output  1  high from CONFIG until return to IDLE or ERROR.
REQ-010 done  output  1  one-cycle pulse when the last layer completes.
REQ-011 error  output  1  sticky timeout flag, cleared by next accepted start or rst.
REQ-012 layer_start  output  1  one-cycle launch pulse to the layer datapath.
REQ-013 layer_done  input  1  one-cycle completion pulse from the layer datapath.
REQ-014 layer_idx  output  $clog2(NUM_LAYERS)  index of the current layer.
REQ-015 weight_base  output  WADDR_W  weight-BRAM base for the current layer.
REQ-016 bias_base  output  BADDR_W  bias-BRAM base for the current layer.
REQ-017 in_depth / out_depth  output  12 each  input/output neuron counts for the current layer.
REQ-018 in_bank / out_bank  output  1 each  activation ping-pong select: read bank / write bank.

Function
REQ-019 States SHALL be IDLE, CONFIG, LAUNCH, RUN, NEXT, FINISH, ERROR.
REQ-020 IDLE: start -> CONFIG with layer_idx=0 and error cleared; start in any other state is ignored.
REQ-021 CONFIG: load weight_base, bias_base, in_depth, out_depth from the layer table at layer_idx -> LAUNCH.
REQ-022 LAUNCH: layer_start=1 for exactly one cycle -> RUN; watchdog cleared.
REQ-023 RUN: watchdog increments each cycle; layer_done -> NEXT; watchdog == TIMEOUT_CYCLES-1 with no layer_done -> ERROR.
REQ-024 NEXT: if layer_idx == NUM_LAYERS-1 -> FINISH, else layer_idx+1 and -> CONFIG.
REQ-025 FINISH: done=1 for one cycle -> IDLE.
REQ-026 ERROR: error=1, busy=0; start -> CONFIG (as from IDLE).
REQ-027 Latency: start at cycle 0 -> layer_start at cycle 2; layer_done at cycle t -> next layer_start at t+3; last layer_done at t -> done at t+2.
REQ-028 in_bank = layer_idx[0], out_bank = ~layer_idx[0]; layer 0 reads bank 0 (image).
REQ-029 All config outputs SHALL be registered and stable from CONFIG exit until the next CONFIG or IDLE.
REQ-030 layer_done outside RUN SHALL be ignored; layer_done and watchdog expiry in the same cycle -> layer_done wins.
REQ-031 abort in any non-IDLE state -> IDLE next cycle, no done, error unchanged; abort has priority over layer_done.
REQ-032 Watchdog width SHALL be $clog2(TIMEOUT_CYCLES)+1; no wrap inside RUN.

Reset
REQ-033 rst -> state IDLE, layer_idx 0, watchdog 0, all outputs 0 (busy, done, error, layer_start, bases, depths, banks).
REQ-034 rst mid-RUN SHALL drop layer_start/busy immediately; no done pulse follows release.

Structure
REQ-035 Shared package mlp_pkg SHALL hold the state enum and per-layer table: depths 3072->512->256->10, weight bases 0, 1572864, 1703936, bias bases 0, 512, 768.
REQ-036 One sub-module is natural: watchdog_counter (clear, enable, expire output).

Verification
REQ-037 start, layer_done 20 cycles after each layer_start -> three layer_starts, bases 0/1572864/1703936, banks 0/1, 1/0, 0/1, one done.
REQ-038 start at cycle 0 -> layer_start at cycle 2; layer_done at cycle 30 -> layer_start at 33; final layer_done at 60 -> done at 62.
REQ-039 TIMEOUT_CYCLES=16, no layer_done -> ERROR 16 cycles after layer_start, error=1, busy=0; new start clears error.
REQ-040 abort during layer 1 RUN -> IDLE next cycle, no done; spurious layer_done in IDLE -> no state change.
REQ-041 start pulsed while busy and layer_done coincident with abort -> both ignored/aborted, single clean run afterwards.
REQ-042 rst asserted asynchronously mid-RUN -> all outputs 0 same cycle, IDLE after release.

Source files
------------

// File: rtl/mlp_sequencer_pkg.sv
// mlp_pkg: sequencer state encoding and the per-layer configuration table
package mlp_pkg;
    typedef enum logic [2:0] {IDLE, CONFIG, LAUNCH, RUN, NEXT, FINISH, ERROR} state_t;
    typedef struct packed {
        logic [20:0] weight_base;
        logic [9:0]  bias_base;
        logic [11:0] in_depth;
        logic [11:0] out_depth;
    } layer_cfg_t;
    function automatic layer_cfg_t layer_cfg(input logic [7:0] idx);
        return idx == 8'd0 ? layer_cfg_t'{21'd0,       10'd0,   12'd3072, 12'd512}
             : idx == 8'd1 ? layer_cfg_t'{21'd1572864, 10'd512, 12'd512,  12'd256}
             : idx == 8'd2 ? layer_cfg_t'{21'd1703936, 10'd768, 12'd256,  12'd10}
             : '0;
    endfunction
endpackage

// File: rtl/mlp_sequencer_if.sv
// mlp_sequencer_if: control handshake and per-layer configuration bus
interface mlp_sequencer_if #(
    parameter int NUM_LAYERS = 3,
    parameter int WADDR_W    = 21,
    parameter int BADDR_W    = 10
);
    localparam int IDX_W = $clog2(NUM_LAYERS);
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic               error;
    logic               layer_start;
    logic               layer_done;
    logic [IDX_W-1:0]   layer_idx;
    logic [WADDR_W-1:0] weight_base;
    logic [BADDR_W-1:0] bias_base;
    logic [11:0]        in_depth;
    logic [11:0]        out_depth;
    logic               in_bank;
    logic               out_bank;
    modport master (
        input  start, abort, layer_done,
        output busy, done, error, layer_start, layer_idx, weight_base, bias_base,
               in_depth, out_depth, in_bank, out_bank
    );
    modport slave (
        output start, abort, layer_done,
        input  busy, done, error, layer_start, layer_idx, weight_base, bias_base,
               in_depth, out_depth, in_bank, out_bank
    );
endinterface

// File: rtl/mlp_sequencer_watchdog.sv
// watchdog_counter: saturating busy-cycle counter that flags a stalled layer
module watchdog_counter #(
    parameter int TIMEOUT_CYCLES = 2097152
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [W-1:0] count;
    assign expire = count == W'(TIMEOUT_CYCLES - 1);
    // count while enabled, holding at the expiry value so it never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (clear) count <= '0;
        else if (enable && !expire) count <= count + 1'b1;
    end
endmodule

// File: rtl/mlp_sequencer.sv
// mlp_sequencer: steps an MLP inference through its layers, one launch/done handshake per layer
module mlp_sequencer
    import mlp_pkg::*;
#(
    parameter int NUM_LAYERS     = 3,
    parameter int TIMEOUT_CYCLES = 2097152,
    parameter int WADDR_W        = 21,
    parameter int BADDR_W        = 10
) (
    input logic clk,
    input logic rst,
    mlp_sequencer_if.master bus
);
    localparam int IDX_W = $clog2(NUM_LAYERS);
    state_t     state, state_n;
    layer_cfg_t cfg;
    logic       expire, last, accept;
    assign cfg    = layer_cfg(8'(bus.layer_idx));
    assign last   = bus.layer_idx == IDX_W'(NUM_LAYERS - 1);
    assign accept = state_n == CONFIG && (state == IDLE || state == ERROR);
    assign bus.busy        = state inside {CONFIG, LAUNCH, RUN, NEXT, FINISH};
    assign bus.done        = state == FINISH;
    assign bus.layer_start = state == LAUNCH;
    watchdog_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == LAUNCH),
        .enable (state == RUN),
        .expire (expire)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // next state; abort overrides everything, layer_done beats watchdog expiry
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? CONFIG : IDLE;
            CONFIG:  state_n = LAUNCH;
            LAUNCH:  state_n = RUN;
            RUN:     state_n = bus.layer_done ? NEXT : expire ? ERROR : RUN;
            NEXT:    state_n = last ? FINISH : CONFIG;
            FINISH:  state_n = IDLE;
            ERROR:   state_n = bus.start ? CONFIG : ERROR;
            default: state_n = IDLE;
        endcase
        if (bus.abort && state != IDLE) state_n = IDLE;
    end
    // layer index, sticky error and registered per-layer configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.layer_idx   <= '0;
            bus.error       <= 1'b0;
            bus.weight_base <= '0;
            bus.bias_base   <= '0;
            bus.in_depth    <= '0;
            bus.out_depth   <= '0;
            bus.in_bank     <= 1'b0;
            bus.out_bank    <= 1'b0;
        end else begin
            if (accept) begin
                bus.layer_idx <= '0;
                bus.error     <= 1'b0;
            end else if (state == NEXT && state_n == CONFIG) begin
                bus.layer_idx <= bus.layer_idx + 1'b1;
            end
            if (state == RUN && state_n == ERROR) bus.error <= 1'b1;
            if (state == CONFIG) begin
                bus.weight_base <= WADDR_W'(cfg.weight_base);
                bus.bias_base   <= BADDR_W'(cfg.bias_base);
                bus.in_depth    <= cfg.in_depth;
                bus.out_depth   <= cfg.out_depth;
                bus.in_bank     <= bus.layer_idx[0];
                bus.out_bank    <= ~bus.layer_idx[0];
            end
        end
    end
endmodule

// File: tb/tb_mlp_sequencer.sv
// tb_mlp_sequencer: directed checks of sequencing, latency, timeout, abort and reset
module tb_mlp_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   n_start = 0;
    int   n_done = 0;
    int   wb_exp [3] = '{0, 1572864, 1703936};
    int   bb_exp [3] = '{0, 512, 768};
    int   id_exp [3] = '{3072, 512, 256};
    int   od_exp [3] = '{512, 256, 10};

    always #5 clk = ~clk;

    mlp_sequencer_if #(.NUM_LAYERS(3), .WADDR_W(21), .BADDR_W(10)) a ();
    mlp_sequencer_if #(.NUM_LAYERS(3), .WADDR_W(21), .BADDR_W(10)) b ();

    mlp_sequencer #(.NUM_LAYERS(3), .TIMEOUT_CYCLES(2097152), .WADDR_W(21), .BADDR_W(10)) dut_a (
        .clk (clk), .rst (rst), .bus (a.master)
    );
    mlp_sequencer #(.NUM_LAYERS(3), .TIMEOUT_CYCLES(16), .WADDR_W(21), .BADDR_W(10)) dut_b (
        .clk (clk), .rst (rst), .bus (b.master)
    );

    always @(posedge clk) begin
        if (a.layer_start) n_start <= n_start + 1;
        if (a.done) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cfg(input string tag, input int l);
        check({tag, "_idx"}, 32'(a.layer_idx), l);
        check({tag, "_wb"}, 32'(a.weight_base), wb_exp[l]);
        check({tag, "_bb"}, 32'(a.bias_base), bb_exp[l]);
        check({tag, "_ind"}, 32'(a.in_depth), id_exp[l]);
        check({tag, "_outd"}, 32'(a.out_depth), od_exp[l]);
        check({tag, "_inb"}, 32'(a.in_bank), l % 2);
        check({tag, "_outb"}, 32'(a.out_bank), 1 - l % 2);
    endtask

    task automatic wait_launch(input string tag);
        int n = 0;
        while (!a.layer_start && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(a.layer_start), 1);
    endtask

    task automatic run_clean(input string tag);
        int s0 = n_start;
        int d0 = n_done;
        int n = 0;
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        for (int l = 0; l < 3; l++) begin
            wait_launch({tag, "_launch"});
            check_cfg(tag, l);
            repeat (20) tick();
            a.layer_done = 1'b1;
            tick();
            a.layer_done = 1'b0;
        end
        while (!a.done && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(a.done), 1);
        tick();
        check({tag, "_idle"}, 32'(a.busy), 0);
        check({tag, "_nstart"}, 32'(n_start - s0), 3);
        check({tag, "_ndone"}, 32'(n_done - d0), 1);
    endtask

    initial begin
        int d0;
        {a.start, a.abort, a.layer_done} = 3'b000;
        {b.start, b.abort, b.layer_done} = 3'b000;
        tick();
        tick();
        check("rst_busy", 32'(a.busy), 0);
        check("rst_done", 32'(a.done), 0);
        check("rst_error", 32'(a.error), 0);
        check("rst_lstart", 32'(a.layer_start), 0);
        check("rst_wb", 32'(a.weight_base), 0);
        check("rst_ind", 32'(a.in_depth), 0);
        check("rst_banks", 32'({a.in_bank, a.out_bank}), 0);
        rst = 1'b0;
        tick();

        // cycle-accurate latency: start@0, done@30, done@45, done@60
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        check("lat_busy1", 32'(a.busy), 1);
        check("lat_ls1", 32'(a.layer_start), 0);
        tick();
        check("lat_ls2", 32'(a.layer_start), 1);
        check_cfg("lat_l0", 0);
        repeat (28) tick();
        a.layer_done = 1'b1;
        tick();
        a.layer_done = 1'b0;
        tick();
        check("lat_ls32", 32'(a.layer_start), 0);
        tick();
        check("lat_ls33", 32'(a.layer_start), 1);
        check_cfg("lat_l1", 1);
        tick();
        check("lat_ls34", 32'(a.layer_start), 0);
        repeat (11) tick();
        a.layer_done = 1'b1;
        tick();
        a.layer_done = 1'b0;
        repeat (2) tick();
        check("lat_ls48", 32'(a.layer_start), 1);
        check_cfg("lat_l2", 2);
        repeat (12) tick();
        a.layer_done = 1'b1;
        tick();
        a.layer_done = 1'b0;
        check("lat_done61", 32'(a.done), 0);
        tick();
        check("lat_done62", 32'(a.done), 1);
        tick();
        check("lat_done63", 32'(a.done), 0);
        check("lat_busy63", 32'(a.busy), 0);

        // abort during layer 1 RUN, then a spurious layer_done while idle
        d0 = n_done;
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        wait_launch("ab_l0");
        tick();
        a.layer_done = 1'b1;
        tick();
        a.layer_done = 1'b0;
        wait_launch("ab_l1");
        check("ab_idx", 32'(a.layer_idx), 1);
        tick();
        a.abort = 1'b1;
        tick();
        a.abort = 1'b0;
        check("ab_busy", 32'(a.busy), 0);
        check("ab_error", 32'(a.error), 0);
        a.layer_done = 1'b1;
        tick();
        a.layer_done = 1'b0;
        repeat (3) tick();
        check("spur_busy", 32'(a.busy), 0);
        check("spur_ls", 32'(a.layer_start), 0);
        check("ab_nodone", 32'(n_done - d0), 0);

        // start while busy is ignored; abort beats a coincident layer_done
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        wait_launch("ign_l0");
        repeat (2) tick();
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        check("ign_idx", 32'(a.layer_idx), 0);
        check("ign_ls", 32'(a.layer_start), 0);
        a.abort = 1'b1;
        a.layer_done = 1'b1;
        tick();
        a.abort = 1'b0;
        a.layer_done = 1'b0;
        check("abld_busy", 32'(a.busy), 0);
        repeat (4) tick();
        check("abld_ls", 32'(a.layer_start), 0);
        check("abld_nodone", 32'(n_done - d0), 0);
        run_clean("clean");

        // watchdog timeout on the TIMEOUT_CYCLES=16 instance
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        tick();
        check("to_ls", 32'(b.layer_start), 1);
        repeat (15) tick();
        check("to_err15", 32'(b.error), 0);
        check("to_busy15", 32'(b.busy), 1);
        repeat (2) tick();
        check("to_err17", 32'(b.error), 1);
        check("to_busy17", 32'(b.busy), 0);
        repeat (3) tick();
        check("to_sticky", 32'(b.error), 1);
        b.abort = 1'b1;
        tick();
        b.abort = 1'b0;
        check("to_abort_err", 32'(b.error), 1);
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        check("to_restart_err", 32'(b.error), 0);
        check("to_restart_busy", 32'(b.busy), 1);
        tick();
        check("to_ls2", 32'(b.layer_start), 1);
        // layer_done on the expiry cycle wins over the timeout
        repeat (16) tick();
        b.layer_done = 1'b1;
        tick();
        b.layer_done = 1'b0;
        check("race_err", 32'(b.error), 0);
        check("race_busy", 32'(b.busy), 1);
        tick();
        check("race_idx", 32'(b.layer_idx), 1);
        b.abort = 1'b1;
        tick();
        b.abort = 1'b0;
        check("race_abort", 32'(b.busy), 0);

        // asynchronous reset asserted mid-cycle during a launch
        d0 = n_done;
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        wait_launch("ar_l0");
        #2;
        rst = 1'b1;
        #1;
        check("ar_ls", 32'(a.layer_start), 0);
        check("ar_busy", 32'(a.busy), 0);
        check("ar_ind", 32'(a.in_depth), 0);
        check("ar_outb", 32'(a.out_bank), 0);
        #1;
        rst = 1'b0;
        repeat (5) tick();
        check("ar_idle", 32'(a.busy), 0);
        check("ar_nodone", 32'(n_done - d0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
